can_tx_fetch: RTL and testbench

Transmit-side frame fetcher between the 128-bit CAN transmit FIFO and the CAN bit-stream transmitter. It pops one frame at a time from the FIFO, holds and unpacks it into CAN fields, and presents it to the transmitter with a valid/ready handshake. It then waits for the transmission outcome and re-presents the held frame on arbitration loss or bus error, up to a retry limit. Nothing is popped from the FIFO until the held frame is either sent or dropped.

---
 rtl/can_tx_fetch.sv | 148 ++++++++++++++
 tb/tb_can_tx_fetch.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_fetch.sv
// can_tx_fetch: pulls one frame at a time from the 128-bit CAN transmit FIFO,
// holds it, offers the unpacked fields to the bit-stream transmitter and
// re-offers the same frame after arbitration loss or bus error until the
// retry limit is used up or the frame is aborted.
module can_tx_fetch #(
    parameter int unsigned MAX_RETRY = 8
) (
    input  logic         i_sys_clk,
    input  logic         i_reset_n,
    input  logic         i_enable,
    input  logic         i_fifo_empty,
    input  logic [127:0] i_fifo_r_data,
    output logic         o_fifo_r_en,
    output logic         o_tx_valid,
    input  logic         i_tx_ready,
    output logic [28:0]  o_tx_id,
    output logic         o_tx_ide,
    output logic         o_tx_rtr,
    output logic [3:0]   o_tx_dlc,
    output logic [3:0]   o_tx_len,
    output logic [63:0]  o_tx_data,
    input  logic         i_tx_done,
    input  logic         i_tx_arb_lost,
    input  logic         i_tx_error,
    input  logic         i_abort,
    output logic         o_tx_ok,
    output logic         o_drop,
    output logic         o_busy,
    output logic [7:0]   o_retry_cnt
);

    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        ACTIVE
    } state_t;

    state_t       state;
    logic [127:0] hold;
    logic         armed;
    logic         abort_pending;
    logic         tx_valid;
    logic         busy;
    logic         tx_ok;
    logic         drop;
    logic [7:0]   retry_cnt;

    logic         fetch;
    logic         failed;
    logic         give_up;
    logic         unused_reserved;

    // armed keeps IDLE for one full cycle after reset release or frame
    // completion, so a pop never lands in the same cycle as o_tx_ok/o_drop.
    assign fetch   = (state == IDLE) && armed && i_enable && !i_fifo_empty;
    assign failed  = i_tx_arb_lost || i_tx_error;
    // An abort arriving together with the failure pulse counts as pending.
    assign give_up = abort_pending || i_abort || (retry_cnt == RETRY_LIMIT);

    // Reserved word bits are captured but have no field to drive.
    assign unused_reserved = ^hold[127:99];

    // Fetch/offer/outcome sequencing with registered status outputs.
    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            hold          <= '0;
            armed         <= 1'b0;
            abort_pending <= 1'b0;
            tx_valid      <= 1'b0;
            busy          <= 1'b0;
            tx_ok         <= 1'b0;
            drop          <= 1'b0;
            retry_cnt     <= '0;
        end else begin
            tx_ok <= 1'b0;
            drop  <= 1'b0;
            case (state)
                IDLE: begin
                    abort_pending <= 1'b0;
                    if (fetch) begin
                        hold      <= i_fifo_r_data;
                        retry_cnt <= '0;
                        armed     <= 1'b0;
                        tx_valid  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= OFFER;
                    end else begin
                        armed <= 1'b1;
                    end
                end
                OFFER: begin
                    if (i_abort) begin
                        drop          <= 1'b1;
                        tx_valid      <= 1'b0;
                        busy          <= 1'b0;
                        abort_pending <= 1'b0;
                        state         <= IDLE;
                    end else if (i_tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (i_tx_done) begin
                        tx_ok         <= 1'b1;
                        busy          <= 1'b0;
                        abort_pending <= 1'b0;
                        state         <= IDLE;
                    end else if (failed) begin
                        if (give_up) begin
                            drop          <= 1'b1;
                            busy          <= 1'b0;
                            abort_pending <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            retry_cnt <= retry_cnt + 8'd1;
                            tx_valid  <= 1'b1;
                            state     <= OFFER;
                        end
                    end else if (i_abort) begin
                        abort_pending <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_fifo_r_en = fetch;
    assign o_tx_valid  = tx_valid;
    assign o_tx_ok     = tx_ok;
    assign o_drop      = drop;
    assign o_busy      = busy;
    assign o_retry_cnt = retry_cnt;

    assign o_tx_data = hold[63:0];
    assign o_tx_dlc  = hold[67:64];
    assign o_tx_rtr  = hold[68];
    assign o_tx_ide  = hold[69];
    assign o_tx_id   = hold[98:70];
    assign o_tx_len  = hold[68] ? 4'd0 : ((hold[67:64] > 4'd8) ? 4'd8 : hold[67:64]);

endmodule

// File: tb/tb_can_tx_fetch.sv
// tb_can_tx_fetch: randomized scoreboard bench for can_tx_fetch. The driver
// plays FIFO and transmitter and queues the expected frames and outcomes;
// the monitor compares them against what the DUT presents.
module tb_can_tx_fetch;

    localparam int MAXR   = 2;
    localparam int K_RETRY = 0;
    localparam int K_OK    = 1;
    localparam int K_DROP  = 2;

    typedef struct packed {
        logic [28:0] id;
        logic        ide;
        logic        rtr;
        logic [3:0]  dlc;
        logic [3:0]  len;
        logic [63:0] data;
    } frame_t;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] retry;
        logic [8:0] offers;
    } outcome_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         fifo_empty;
    logic [127:0] fifo_data;
    logic         fifo_r_en;
    logic         tx_valid;
    logic         tx_ready;
    logic [28:0]  tx_id;
    logic         tx_ide;
    logic         tx_rtr;
    logic [3:0]   tx_dlc;
    logic [3:0]   tx_len;
    logic [63:0]  tx_data;
    logic         tx_done;
    logic         tx_arb_lost;
    logic         tx_error;
    logic         tx_abort;
    logic         tx_ok;
    logic         drop;
    logic         busy;
    logic [7:0]   retry_cnt;

    logic [127:0] fifo_mem [0:255];
    logic [7:0]   wr_ptr;
    logic [7:0]   rd_ptr = 8'd0;

    frame_t   exp_frames[$];
    outcome_t exp_outs[$];

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    bit  stim_done = 1'b0;
    bit  mon_done = 1'b0;

    can_tx_fetch #(.MAX_RETRY(MAXR)) dut (
        .i_sys_clk     (clk),
        .i_reset_n     (rst_n),
        .i_enable      (enable),
        .i_fifo_empty  (fifo_empty),
        .i_fifo_r_data (fifo_data),
        .o_fifo_r_en   (fifo_r_en),
        .o_tx_valid    (tx_valid),
        .i_tx_ready    (tx_ready),
        .o_tx_id       (tx_id),
        .o_tx_ide      (tx_ide),
        .o_tx_rtr      (tx_rtr),
        .o_tx_dlc      (tx_dlc),
        .o_tx_len      (tx_len),
        .o_tx_data     (tx_data),
        .i_tx_done     (tx_done),
        .i_tx_arb_lost (tx_arb_lost),
        .i_tx_error    (tx_error),
        .i_abort       (tx_abort),
        .o_tx_ok       (tx_ok),
        .o_drop        (drop),
        .o_busy        (busy),
        .o_retry_cnt   (retry_cnt)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_data  = fifo_mem[rd_ptr];

    // FIFO read side: advance the head on every pop the DUT issues.
    always @(posedge clk) begin
        if (fifo_r_en && !fifo_empty) rd_ptr <= rd_ptr + 8'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic outcome_t mkOut(input int kind, input int retry, input int offers);
        outcome_t o;
        o.kind   = 2'(kind);
        o.retry  = 8'(retry);
        o.offers = 9'(offers);
        return o;
    endfunction

    // Compose a FIFO word from CAN fields and queue the fields the
    // transmitter is expected to see, with len = min(dlc, 8), 0 for remote.
    task automatic pushFrame(input logic [28:0] id, input logic ide, input logic rtr,
                             input int dlc, input logic [63:0] data);
        frame_t       f;
        logic [28:0]  junk;
        junk   = 29'($urandom);
        f.id   = id;
        f.ide  = ide;
        f.rtr  = rtr;
        f.dlc  = 4'(dlc);
        f.data = data;
        if (rtr)          f.len = 4'd0;
        else if (dlc > 8) f.len = 4'd8;
        else              f.len = 4'(dlc);
        fifo_mem[wr_ptr] = {junk, id, ide, rtr, 4'(dlc), data};
        wr_ptr = wr_ptr + 8'd1;
        exp_frames.push_back(f);
    endtask

    task automatic waitValid();
        int t;
        t = 0;
        while (!tx_valid) begin
            tick();
            t++;
            if (t > 60) begin
                $display("[TB] FAIL offer_timeout: o_tx_valid=0 after %0d cycles, required 1", t);
                $fatal(1, "[TB] stopping on offer timeout");
            end
        end
    endtask

    task automatic pulseFail(input int fail_kind);
        int k;
        k = (fail_kind == 2) ? int'($urandom_range(0, 1)) : fail_kind;
        if (k == 0) tx_arb_lost = 1'b1;
        else        tx_error    = 1'b1;
        tick();
        tx_arb_lost = 1'b0;
        tx_error    = 1'b0;
    endtask

    // Play the transmitter for one held frame: n_fail failures are issued
    // until the frame succeeds, hits the retry limit or is aborted.
    // abort_mode: 0 none, 1 abort with ready on first offer, 2 abort in ACTIVE.
    task automatic applyStimulus(input int n_fail, input int abort_mode, input int fail_kind,
                                 input bit spurious, input bit quick);
        int retry;
        int fails;
        bit pending;
        bit first;
        retry   = 0;
        fails   = 0;
        pending = 1'b0;
        first   = 1'b1;
        forever begin
            waitValid();
            if (spurious && first) begin
                if ($urandom_range(0, 1) == 0) tx_done = 1'b1;
                else                           tx_arb_lost = 1'b1;
                tick();
                tx_done     = 1'b0;
                tx_arb_lost = 1'b0;
            end
            if (abort_mode == 1 && first) begin
                exp_outs.push_back(mkOut(K_DROP, retry, retry + 1));
                tx_ready = 1'b1;
                tx_abort = 1'b1;
                tick();
                tx_ready = 1'b0;
                tx_abort = 1'b0;
                return;
            end
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
            if (!quick) repeat ($urandom_range(0, 2)) tick();
            if (abort_mode == 2 && first) begin
                tx_abort = 1'b1;
                pending  = 1'b1;
                tick();
                tx_abort = 1'b0;
            end
            first = 1'b0;
            if (fails < n_fail) begin
                fails++;
                if (pending || retry == MAXR) begin
                    exp_outs.push_back(mkOut(K_DROP, retry, retry + 1));
                    pulseFail(fail_kind);
                    return;
                end
                retry++;
                exp_outs.push_back(mkOut(K_RETRY, retry, 0));
                pulseFail(fail_kind);
            end else begin
                exp_outs.push_back(mkOut(K_OK, retry, retry + 1));
                tx_done = 1'b1;
                tick();
                tx_done = 1'b0;
                return;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int       last_pop = -10;
    int       last_term = -10;
    int       offers = 0;
    bit       held = 1'b0;
    bit       prev_valid = 1'b0;
    bit       prev_rst = 1'b0;
    bit       rel_pending = 1'b0;
    bit       chk_reoffer = 1'b0;
    logic [7:0] reoffer_retry;
    outcome_t mon_out;
    logic [1:0] exp_flags;

    // Monitor: samples on the falling edge and pops the scoreboard queues
    // whenever the DUT pops, offers, re-offers or reports an outcome.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            checkOutput("reset_outputs",
                128'({fifo_r_en, tx_valid, tx_ok, drop, busy, retry_cnt,
                      tx_id, tx_ide, tx_rtr, tx_dlc, tx_len, tx_data}), 128'(0));
            if (held) exp_frames.delete(0);
            held        = 1'b0;
            offers      = 0;
            chk_reoffer = 1'b0;
            prev_valid  = 1'b0;
            prev_rst    = 1'b0;
            rel_pending = 1'b0;
        end else begin
            if (!prev_rst) begin
                checkOutput("release_cycle_no_pop", 128'(fifo_r_en), 128'(0));
                rel_pending = 1'b1;
            end else if (rel_pending) begin
                rel_pending = 1'b0;
                if (enable && !fifo_empty)
                    checkOutput("first_pop_after_release", 128'(fifo_r_en), 128'(1));
            end
            if (last_term == cyc - 1 && enable && !fifo_empty)
                checkOutput("b2b_pop", 128'(fifo_r_en), 128'(1));
            if (fifo_r_en) begin
                checkOutput("pop_nonempty", 128'(fifo_empty), 128'(0));
                checkOutput("pop_enabled", 128'(enable), 128'(1));
                checkOutput("pop_idle", 128'(busy), 128'(0));
                checkOutput("pop_spacing", 128'(cyc - last_term >= 1), 128'(1));
                last_pop = cyc;
                held     = 1'b1;
            end
            if (chk_reoffer) begin
                chk_reoffer = 1'b0;
                checkOutput("reoffer_valid", 128'(tx_valid), 128'(1));
                checkOutput("reoffer_retry_cnt", 128'(retry_cnt), 128'(reoffer_retry));
            end
            if (tx_valid && !prev_valid) begin
                checkOutput("offer_has_frame", 128'(exp_frames.size() > 0), 128'(1));
                if (exp_frames.size() > 0)
                    checkOutput("fields",
                        128'({tx_id, tx_ide, tx_rtr, tx_dlc, tx_len, tx_data}),
                        128'(exp_frames[0]));
                if (offers == 0) checkOutput("fetch_latency", 128'(cyc - last_pop), 128'(1));
                offers++;
            end
            if ((tx_arb_lost || tx_error) && exp_outs.size() > 0 && exp_outs[0].kind == 2'(K_RETRY)) begin
                reoffer_retry = exp_outs[0].retry;
                exp_outs.delete(0);
                chk_reoffer = 1'b1;
            end
            if (tx_ok || drop) begin
                checkOutput("ok_drop_exclusive", 128'(tx_ok && drop), 128'(0));
                if (exp_outs.size() == 0) begin
                    checkOutput("unexpected_outcome", 128'({tx_ok, drop}), 128'(0));
                end else begin
                    mon_out = exp_outs[0];
                    exp_outs.delete(0);
                    exp_flags = (mon_out.kind == 2'(K_OK)) ? 2'b10 :
                                (mon_out.kind == 2'(K_DROP)) ? 2'b01 : 2'b00;
                    checkOutput("outcome_kind", 128'({tx_ok, drop}), 128'(exp_flags));
                    checkOutput("final_retry_cnt", 128'(retry_cnt), 128'(mon_out.retry));
                    checkOutput("offer_count", 128'(offers), 128'(mon_out.offers));
                end
                if (exp_frames.size() > 0) exp_frames.delete(0);
                checkOutput("idle_after_outcome", 128'(busy), 128'(0));
                held      = 1'b0;
                offers    = 0;
                last_term = cyc;
            end
            prev_valid = tx_valid;
            prev_rst   = 1'b1;
        end
        if (stim_done && !mon_done) begin
            checkOutput("leftover_outcomes", 128'(exp_outs.size()), 128'(0));
            checkOutput("leftover_frames", 128'(exp_frames.size()), 128'(0));
            mon_done = 1'b1;
        end
    end

    // Directed scenarios first, then a randomized run, then reset mid-frame.
    initial begin
        logic [28:0] rid;
        logic        ride;
        int          t;
        rst_n       = 1'b0;
        enable      = 1'b1;
        tx_ready    = 1'b0;
        tx_done     = 1'b0;
        tx_arb_lost = 1'b0;
        tx_error    = 1'b0;
        tx_abort    = 1'b0;
        wr_ptr      = 8'd0;

        pushFrame(29'h1ABCDE01, 1'b1, 1'b0, 5, 64'h1122334455667788);
        repeat (3) tick();
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 1'b0, 1'b0);

        pushFrame(29'h0123_4567, 1'b1, 1'b0, 12, 64'hDEADBEEF_CAFEF00D);
        applyStimulus(0, 0, 0, 1'b0, 1'b0);
        pushFrame({11'h5A5, 18'h0}, 1'b0, 1'b1, 4, 64'h0102030405060708);
        applyStimulus(0, 0, 0, 1'b0, 1'b0);

        pushFrame(29'h1FFFFFFF, 1'b1, 1'b0, 8, 64'hFFEEDDCCBBAA9988);
        applyStimulus(MAXR + 1, 0, 0, 1'b0, 1'b0);
        pushFrame({11'h7FF, 18'h0}, 1'b0, 1'b0, 0, 64'h0);
        applyStimulus(1, 0, 1, 1'b0, 1'b0);

        pushFrame(29'h00000001, 1'b1, 1'b0, 3, 64'hA5A5A5A5A5A5A5A5);
        applyStimulus(0, 1, 0, 1'b0, 1'b0);
        pushFrame(29'h00000002, 1'b1, 1'b0, 7, 64'h5A5A5A5A5A5A5A5A);
        applyStimulus(1, 2, 0, 1'b0, 1'b0);
        pushFrame(29'h00000003, 1'b1, 1'b1, 15, 64'h1234);
        applyStimulus(0, 2, 0, 1'b0, 1'b0);

        enable = 1'b0;
        pushFrame(29'h0ABCDEF0, 1'b1, 1'b0, 2, 64'h77);
        repeat (3) tick();
        tx_done = 1'b1;
        tick();
        tx_done     = 1'b0;
        tx_arb_lost = 1'b1;
        tick();
        tx_arb_lost = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        applyStimulus(0, 0, 0, 1'b0, 1'b0);

        pushFrame(29'h0BADC0DE, 1'b1, 1'b0, 6, 64'h8899AABBCCDDEEFF);
        waitValid();
        enable = 1'b0;
        applyStimulus(1, 0, 2, 1'b0, 1'b0);
        pushFrame(29'h0000BEEF, 1'b1, 1'b0, 1, 64'h42);
        repeat (6) tick();
        enable = 1'b1;
        applyStimulus(0, 0, 0, 1'b0, 1'b0);

        enable = 1'b0;
        pushFrame(29'h00000011, 1'b1, 1'b0, 1, 64'h11);
        pushFrame(29'h00000022, 1'b1, 1'b0, 2, 64'h2222);
        pushFrame(29'h00000033, 1'b1, 1'b0, 3, 64'h333333);
        tick();
        enable = 1'b1;
        repeat (3) applyStimulus(0, 0, 0, 1'b0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            int am;
            int nq;
            nq = ($urandom_range(0, 3) == 0) ? 2 : 1;
            for (int j = 0; j < nq; j++) begin
                ride = 1'($urandom);
                rid  = ride ? 29'($urandom) : {11'($urandom), 18'h0};
                pushFrame(rid, ride, 1'($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 15)), {$urandom, $urandom});
            end
            for (int j = 0; j < nq; j++) begin
                am = int'($urandom_range(0, 5));
                if (am > 2) am = 0;
                applyStimulus(int'($urandom_range(0, MAXR + 1)), am, 2,
                              1'($urandom_range(0, 3) == 0), 1'($urandom));
            end
        end

        pushFrame(29'h15555555, 1'b1, 1'b0, 8, 64'h0F0F0F0F0F0F0F0F);
        waitValid();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        stim_done = 1'b1;
        t = 0;
        while (!mon_done && t < 10) begin
            tick();
            t++;
        end
        if (!mon_done) begin
            $display("[TB] FAIL monitor_timeout: monitor did not finish, required finish within 10 cycles");
            $fatal(1, "[TB] stopping on monitor timeout");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
